// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, direct-mapped instruction cache and a
// registered one-instruction output stage, backed by memctrl on a miss.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC          = 32'h0,
  parameter int unsigned ICACHE_INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_read_or_not,
  output logic [31:0] intru_addr,
  input  logic        if_load_done,
  input  logic [31:0] mem_ctrl_instru_to_if,
  input  logic        issue_stall,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned Lines = 1 << ICACHE_INDEX_BITS;
  localparam int unsigned TagW  = 30 - ICACHE_INDEX_BITS;

  typedef enum logic [0:0] {StRun, StFetch} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        discard_q, discard_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [Lines-1:0] valid_q, valid_d;

  logic [TagW-1:0] tag_q  [Lines];
  logic [31:0]     data_q [Lines];

  logic [ICACHE_INDEX_BITS-1:0] idx, fill_idx;
  logic [TagW-1:0]              tag, fill_tag;
  logic                         hit, can_load, fill_en;

  assign idx      = pc_q[ICACHE_INDEX_BITS+1:2];
  assign tag      = pc_q[31:ICACHE_INDEX_BITS+2];
  assign fill_idx = fetch_addr_q[ICACHE_INDEX_BITS+1:2];
  assign fill_tag = fetch_addr_q[31:ICACHE_INDEX_BITS+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign can_load = !inst_valid_q || !issue_stall;

  // Request drops in the done cycle so memctrl never sees a restart.
  assign if_read_or_not = rst_in && (state_q == StFetch) && !if_load_done;
  assign intru_addr     = fetch_addr_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    discard_d    = discard_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fill_en      = 1'b0;

    if (jump_flag) begin
      inst_valid_d = 1'b0;
      pc_d         = {jump_target[31:2], 2'b00};
      if (state_q == StFetch) begin
        if (if_load_done) begin
          fill_en   = 1'b1;
          state_d   = StRun;
          discard_d = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (hit) begin
            if (can_load) begin
              inst_d       = data_q[idx];
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end
          end else begin
            state_d      = StFetch;
            fetch_addr_d = pc_q;
            if (can_load) inst_valid_d = 1'b0;
          end
        end
        StFetch: begin
          if (can_load) inst_valid_d = 1'b0;
          if (if_load_done) begin
            fill_en   = 1'b1;
            state_d   = StRun;
            discard_d = 1'b0;
            // Resume at the fetched address unless a redirect moved the PC away.
            pc_d      = discard_q ? pc_q : fetch_addr_q;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every lookup.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_ctrl_instru_to_if;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency memctrl responder.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done = 1'b0;
  logic [31:0] mem_word = 32'h0;
  logic        issue_stall;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;
  int nreq   = 0;
  int cnt    = 0;
  int base;

  localparam int Lat = 5;

  always #5 clk_in = ~clk_in;

  if_fetch_unit #(
    .RESET_PC          (32'h0),
    .ICACHE_INDEX_BITS (6)
  ) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .if_read_or_not        (if_read_or_not),
    .intru_addr            (intru_addr),
    .if_load_done          (if_load_done),
    .mem_ctrl_instru_to_if (mem_word),
    .issue_stall           (issue_stall),
    .jump_flag             (jump_flag),
    .jump_target           (jump_target),
    .inst_valid            (inst_valid),
    .inst                  (inst),
    .inst_pc               (inst_pc)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h13 + (a << 8);
  endfunction

  // memctrl model: answers a held request Lat cycles later with a one-cycle done pulse.
  always @(negedge clk_in) begin
    if (if_load_done) begin
      if_load_done = 1'b0;
    end else if (!if_read_or_not) begin
      cnt = 0;
    end else begin
      if (cnt == 0) nreq++;
      cnt++;
      if (cnt == Lat) begin
        if_load_done = 1'b1;
        mem_word     = rom(intru_addr);
        cnt          = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk_in);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!if_load_done && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_done"}, {31'h0, if_load_done}, 32'h1);
  endtask

  // Miss at a, then the word must appear two samples after done.
  task automatic fetch_and_deliver(input logic [31:0] a, input string tag);
    wait_done(tag);
    chk({tag, "_req_drop"}, {31'h0, if_read_or_not}, 32'h0);
    chk({tag, "_addr"}, intru_addr, a);
    step();
    chk({tag, "_fill_nv"}, {31'h0, inst_valid}, 32'h0);
    step();
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({tag, "_pc"}, inst_pc, a);
    chk({tag, "_inst"}, inst, rom(a));
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; issue_stall = 1'b0; jump_flag = 1'b0; jump_target = 32'h0;
    step();
    step();
    chk("rst_req", {31'h0, if_read_or_not}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    rst_in = 1'b1;
    step();
    chk("boot_req", {31'h0, if_read_or_not}, 32'h1);
    chk("boot_addr", intru_addr, 32'h0);
    fetch_and_deliver(32'h0, "boot");
    fetch_and_deliver(32'h4, "p1_4");
    fetch_and_deliver(32'h8, "p1_8");
    fetch_and_deliver(32'hC, "p1_c");

    // Redirect to 0; low target bits must be dropped.
    jump_flag = 1'b1; jump_target = 32'h3;
    step();
    jump_flag = 1'b0;
    chk("jmp_kill", {31'h0, inst_valid}, 32'h0);
    base = nreq;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p2_valid", {31'h0, inst_valid}, 32'h1);
      chk("p2_pc", inst_pc, 32'(4 * i));
      chk("p2_inst", inst, rom(32'(4 * i)));
    end

    jump_flag = 1'b1; jump_target = 32'h0;
    step();
    jump_flag = 1'b0;
    step();
    chk("p3_pc0", inst_pc, 32'h0);
    rdy_in = 1'b0;
    step();
    step();
    chk("rdy_hold_pc", inst_pc, 32'h0);
    chk("rdy_hold_valid", {31'h0, inst_valid}, 32'h1);
    rdy_in = 1'b1;
    step();
    chk("p3_pc4", inst_pc, 32'h4);
    step();
    chk("p3_pc8", inst_pc, 32'h8);
    issue_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_pc", inst_pc, 32'h8);
      chk("stall_inst", inst, rom(32'h8));
    end
    issue_stall = 1'b0;
    step();
    chk("unstall_pc", inst_pc, 32'hC);
    chk("unstall_inst", inst, rom(32'hC));
    chk("cached_no_req", nreq, base);

    // Miss at 0x40, redirected to 0x100 two cycles into the fetch.
    jump_flag = 1'b1; jump_target = 32'h40;
    step();
    jump_flag = 1'b0;
    step();
    chk("m40_req", {31'h0, if_read_or_not}, 32'h1);
    chk("m40_addr", intru_addr, 32'h40);
    step();
    jump_flag = 1'b1; jump_target = 32'h100;
    step();
    jump_flag = 1'b0;
    chk("m40_stale_addr", intru_addr, 32'h40);
    chk("m40_stale_req", {31'h0, if_read_or_not}, 32'h1);
    wait_done("m40");
    chk("m40_done_addr", intru_addr, 32'h40);
    chk("m40_req_drop", {31'h0, if_read_or_not}, 32'h0);
    step();
    chk("m40_discard", {31'h0, inst_valid}, 32'h0);
    step();
    chk("m100_req", {31'h0, if_read_or_not}, 32'h1);
    chk("m100_addr", intru_addr, 32'h100);
    chk("m100_nv", {31'h0, inst_valid}, 32'h0);
    base = nreq;

    // Redirect coincident with done: fill at 0x100, then look up 0x40.
    wait_done("m100");
    chk("m100_done_addr", intru_addr, 32'h100);
    jump_flag = 1'b1; jump_target = 32'h40;
    step();
    jump_flag = 1'b0;
    chk("coin_nv", {31'h0, inst_valid}, 32'h0);
    chk("coin_req", {31'h0, if_read_or_not}, 32'h0);
    step();
    chk("hit40_valid", {31'h0, inst_valid}, 32'h1);
    chk("hit40_pc", inst_pc, 32'h40);
    chk("hit40_inst", inst, rom(32'h40));
    jump_flag = 1'b1; jump_target = 32'h100;
    step();
    jump_flag = 1'b0;
    step();
    chk("hit100_valid", {31'h0, inst_valid}, 32'h1);
    chk("hit100_pc", inst_pc, 32'h100);
    chk("hit100_inst", inst, rom(32'h100));
    chk("coin_no_req", nreq, base);

    // 0x100 evicted line 0; re-fetch 0, then reset in the middle of the 0x10 miss.
    jump_flag = 1'b1; jump_target = 32'h0;
    step();
    jump_flag = 1'b0;
    fetch_and_deliver(32'h0, "refill");
    for (int n = 0; n < 50 && !if_read_or_not; n++) step();
    chk("m10_addr", intru_addr, 32'h10);
    step();
    rst_in = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, if_read_or_not}, 32'h0);
    step();
    chk("rst2_req", {31'h0, if_read_or_not}, 32'h0);
    chk("rst2_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst2_inst", inst, 32'h0);
    chk("rst2_inst_pc", inst_pc, 32'h0);
    base = nreq;
    rst_in = 1'b1;
    step();
    chk("rst2_refetch_req", {31'h0, if_read_or_not}, 32'h1);
    chk("rst2_refetch_addr", intru_addr, 32'h0);
    chk("rst2_refetch_cnt", nreq, base + 1);
    fetch_and_deliver(32'h0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end. It is the requesting side of the memctrl instruction-read interface.
- Holds a PC and a direct-mapped instruction cache.
- On a miss, issues 32-bit read requests to memctrl and waits for the completion pulse. Fills the cache and hands one instruction per cycle to the decode/issue stage.
- Handles branch redirects and downstream back-pressure.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- ICACHE_INDEX_BITS, 6, log2 of the number of cache lines (64 lines, one 32-bit word each).

Ports:
- clk_in  input  1  system clock, all state updates on rising edge
- rst_in  input  1  synchronous reset, active-low (0 = reset)
- rdy_in  input  1  global ready; 0 freezes all state
- if_read_or_not  output  1  instruction read request to memctrl
- intru_addr  output  32  instruction byte address to memctrl
- if_load_done  input  1  one-cycle completion pulse from memctrl
- mem_ctrl_instru_to_if  input  32  fetched word, valid while if_load_done=1
- issue_stall  input  1  downstream cannot accept this cycle
- jump_flag  input  1  redirect request, one-cycle pulse
- jump_target  input  32  redirect PC; bits [1:0] ignored (forced 0)
- inst_valid  output  1  inst/inst_pc hold a deliverable instruction
- inst  output  32  instruction word
- inst_pc  output  32  PC of inst

Behaviour:
- Reset (rst_in=0 at posedge):
  - pc<=RESET_PC; all cache valid bits<=0; state<=RUN.
  - inst_valid<=0, inst<=0, inst_pc<=0, discard<=0.
  - if_read_or_not=0 during the reset cycle, even if a fetch was in flight.
- rdy_in=0: no register changes; outputs hold their values; the request level is held.
- Cache addressing:
  - index = pc[ICACHE_INDEX_BITS+1:2]; tag = pc[31:ICACHE_INDEX_BITS+2].
  - hit = valid[index] && tag match; lookup is combinational.
- Output register rules:
  - Loads when (!inst_valid || !issue_stall).
  - While inst_valid && issue_stall: inst, inst_pc and inst_valid are held stable.
- States:
  - RUN:
    - If hit and the output register can load: inst<=line, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
    - If the output register can load but there is no hit: inst_valid<=0.
    - Miss: state<=FETCH; no delivery.
    - Back-to-back hits sustain 1 instruction/cycle.
  - FETCH:
    - if_read_or_not = (state==FETCH) && !if_load_done (combinational). The request drops in the same cycle done is seen, so memctrl does not restart.
    - intru_addr = pc, held constant for the whole fetch.
    - On if_load_done: write the word, tag and valid to line index; state<=RUN.
    - If discard=0, RUN then delivers the word via the hit path on the following cycle.
    - If discard=1, the word is written to the cache but not delivered; discard<=0.
- Redirect (jump_flag=1, highest priority after reset/rdy):
  - inst_valid<=0 (overrides issue_stall hold); pc<=jump_target & ~3.
  - In RUN: the state stays RUN.
  - In FETCH without if_load_done: state stays FETCH; discard<=1; intru_addr keeps the OLD address until done. pc is updated to the target, so hold the in-flight address in a separate fetch_addr register that is captured on FETCH entry; intru_addr = fetch_addr.
  - FETCH with jump_flag and if_load_done in the same cycle: fill at fetch_addr; state<=RUN; pc<=target; no delivery.
- Fill indexing: the fill uses the index and tag of fetch_addr, never the current pc.
- Latency:
  - Hit to inst_valid: 1 cycle.
  - Miss: 1 cycle (RUN->FETCH), plus memctrl latency (done observed), plus 1 cycle to cache-hit delivery.
- Arithmetic: pc+4 is a 32-bit wraparound; 32'hFFFFFFFC+4 = 0.
- Memctrl may service data-memory accesses first. The request is held indefinitely until done, with no timeout.

Test Plan:
- Reset with RESET_PC=0 and memctrl model returning 32'h00000013 after 5 cycles:
  - if_read_or_not=1 with intru_addr=0 the cycle after reset release.
  - Request drops in the done cycle.
  - inst_valid=1, inst=32'h13, inst_pc=0 one cycle after done.
- Straight-line loop of 4 instructions at 0x0–0xC; jump_flag to 0x0 after the first pass:
  - Second pass has zero memctrl requests.
  - inst_valid=1 on 4 consecutive cycles with inst_pc 0,4,8,C.
- Hold issue_stall=1 for 3 cycles while inst_valid=1 at inst_pc=0x8:
  - inst and inst_pc stay 0x8 / same word.
  - pc does not advance past 0xC.
- Miss at 0x40; jump_flag to 0x100 two cycles into the fetch:
  - intru_addr stays 0x40 until done.
  - Word is not delivered but line 0x40 becomes valid.
  - Next request is for 0x100.
- jump_flag coincident with if_load_done:
  - Fill performed at the old address.
  - No delivery.
  - pc=target; the next cycle is a RUN lookup of the target.
- rst_in=0 asserted mid-fetch, then released:
  - if_read_or_not=0 in the reset cycle.
  - Cache fully invalid (re-fetch of 0x0 occurs).
  - inst_valid=0.
